// File: rtl/alu_op_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_issue
// Description : Execute-stage ALU front end. Decodes RV64I instruction words
//               into a 4-bit ALU opcode plus operand-B select and branch
//               polarity, and buffers the decoded ops in a 2-entry FIFO.
//               The FIFO has valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_issue #(
    parameter int TAG_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_aluop,
    output logic             out_b_imm,
    output logic             out_branch,
    output logic             out_br_on_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // ALU operation codes (NOR exists in the ALU but is never issued from here)
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_or   = 4'b0001;
    localparam logic [3:0] c_alu_add  = 4'b0010;
    localparam logic [3:0] c_alu_xor  = 4'b0011;
    localparam logic [3:0] c_alu_sll  = 4'b0100;
    localparam logic [3:0] c_alu_srl  = 4'b0101;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_slt  = 4'b0111;
    localparam logic [3:0] c_alu_sltu = 4'b1000;
    localparam logic [3:0] c_alu_sra  = 4'b1001;
    localparam logic [3:0] c_alu_nop  = 4'b1111;

    // Major opcodes
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;

    // Entry layout: {aluop[3:0], b_imm, branch, br_on_zero, illegal, tag}
    localparam int ENTRY_W = 8 + TAG_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [5:0]          w_funct6;
    logic                w_unused_instr_bits;

    logic [3:0]          w_aluop;
    logic                w_b_imm;
    logic                w_branch;
    logic                w_br_on_zero;
    logic                w_legal;
    logic [ENTRY_W-1:0]  w_entry;
    logic [ENTRY_W-1:0]  w_head;

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push;
    logic                w_pop;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    // RV64 shift amounts are 6 bits wide, so immediate shifts qualify on [31:26]
    assign w_funct6 = in_instr[31:26];
    assign w_unused_instr_bits = ^{in_instr[24:15], in_instr[11:7]};

    // Combinational decode of the offered instruction word
    always_comb begin
        w_aluop      = c_alu_nop;
        w_b_imm      = 1'b0;
        w_branch     = 1'b0;
        w_br_on_zero = 1'b0;
        w_legal      = 1'b0;
        case (w_opcode)
            c_opc_op: begin
                w_legal = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  w_aluop = c_alu_add;
                        3'b001:  w_aluop = c_alu_sll;
                        3'b010:  w_aluop = c_alu_slt;
                        3'b011:  w_aluop = c_alu_sltu;
                        3'b100:  w_aluop = c_alu_xor;
                        3'b101:  w_aluop = c_alu_srl;
                        3'b110:  w_aluop = c_alu_or;
                        default: w_aluop = c_alu_and;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000) begin
                        w_aluop = c_alu_sub;
                    end else if (w_funct3 == 3'b101) begin
                        w_aluop = c_alu_sra;
                    end else begin
                        w_legal = 1'b0;
                    end
                end else begin
                    w_legal = 1'b0;
                end
            end
            c_opc_op_imm: begin
                w_legal = 1'b1;
                w_b_imm = 1'b1;
                case (w_funct3)
                    3'b000: w_aluop = c_alu_add;
                    3'b001: begin
                        w_aluop = c_alu_sll;
                        w_legal = (w_funct6 == 6'b000000);
                    end
                    3'b010: w_aluop = c_alu_slt;
                    3'b011: w_aluop = c_alu_sltu;
                    3'b100: w_aluop = c_alu_xor;
                    3'b101: begin
                        if (w_funct6 == 6'b000000) begin
                            w_aluop = c_alu_srl;
                        end else if (w_funct6 == 6'b010000) begin
                            w_aluop = c_alu_sra;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    3'b110:  w_aluop = c_alu_or;
                    default: w_aluop = c_alu_and;
                endcase
            end
            c_opc_load, c_opc_store, c_opc_jalr, c_opc_auipc, c_opc_lui: begin
                w_legal = 1'b1;
                w_b_imm = 1'b1;
                w_aluop = c_alu_add;
            end
            c_opc_branch: begin
                w_legal  = 1'b1;
                w_branch = 1'b1;
                case (w_funct3)
                    3'b000: begin w_aluop = c_alu_sub;  w_br_on_zero = 1'b1; end
                    3'b001: begin w_aluop = c_alu_sub;  w_br_on_zero = 1'b0; end
                    3'b100: begin w_aluop = c_alu_slt;  w_br_on_zero = 1'b0; end
                    3'b101: begin w_aluop = c_alu_slt;  w_br_on_zero = 1'b1; end
                    3'b110: begin w_aluop = c_alu_sltu; w_br_on_zero = 1'b0; end
                    3'b111: begin w_aluop = c_alu_sltu; w_br_on_zero = 1'b1; end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal encodings are normalised so the ALU sees a clean NOP
        if (!w_legal) begin
            w_aluop      = c_alu_nop;
            w_b_imm      = 1'b0;
            w_branch     = 1'b0;
            w_br_on_zero = 1'b0;
        end
    end

    assign w_entry = {w_aluop, w_b_imm, w_branch, w_br_on_zero, ~w_legal, in_tag};

    // Ready depends only on registered occupancy, never on out_ready
    assign in_ready = (r_count != c_full) & ~reset;
    assign w_push   = in_valid & in_ready & ~flush;
    assign w_pop    = out_valid & out_ready;

    // Occupancy and pointer tracking; flush and reset both empty the buffer
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed while counted as valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Present the head entry, or the idle NOP pattern when empty
    always_comb begin
        out_valid      = (r_count != '0);
        out_aluop      = c_alu_nop;
        out_b_imm      = 1'b0;
        out_branch     = 1'b0;
        out_br_on_zero = 1'b0;
        out_illegal    = 1'b0;
        out_tag        = '0;
        if (out_valid) begin
            {out_aluop, out_b_imm, out_branch, out_br_on_zero, out_illegal, out_tag} = w_head;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_issue
// Description : Directed self-checking bench for alu_op_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_issue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_aluop;
    logic        out_b_imm;
    logic        out_branch;
    logic        out_br_on_zero;
    logic        out_illegal;
    logic [7:0]  out_tag;

    int n_vec;
    int n_err;

    // {valid, aluop, b_imm, branch, br_on_zero, illegal, tag}
    logic [16:0] obs;
    assign obs = {out_valid, out_aluop, out_b_imm, out_branch, out_br_on_zero, out_illegal, out_tag};

    localparam logic [16:0] c_idle = {1'b0, 4'hF, 4'b0000, 8'h00};

    // Decode table: instruction and expected {aluop, b_imm, branch, br_on_zero, illegal}
    logic [31:0] tbl_instr [25] = '{
        32'h000000B7, 32'h00002003, 32'h00002023, 32'h00000067, 32'h00000017,
        32'h00000063, 32'h00004063, 32'h0000E063, 32'h0000F063, 32'h00002063,
        32'h00001033, 32'h00002033, 32'h00003033, 32'h00004033, 32'h00005033,
        32'h00006033, 32'h40007033, 32'h02001013, 32'h04001013, 32'h40005013,
        32'h00005013, 32'h20005013, 32'h40000013, 32'h0000001B, 32'h00007013
    };
    logic [7:0] tbl_exp [25] = '{
        8'h28, 8'h28, 8'h28, 8'h28, 8'h28,
        8'h66, 8'h74, 8'h84, 8'h86, 8'hF1,
        8'h40, 8'h70, 8'h80, 8'h30, 8'h50,
        8'h10, 8'hF1, 8'h48, 8'hF1, 8'h98,
        8'h58, 8'hF1, 8'h28, 8'hF1, 8'h08
    };

    alu_op_issue #(.TAG_W(8), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_aluop      (out_aluop),
        .out_b_imm      (out_b_imm),
        .out_branch     (out_branch),
        .out_br_on_zero (out_br_on_zero),
        .out_illegal    (out_illegal),
        .out_tag        (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [7:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        tick(); tick();
        n_vec++;
        if (obs !== c_idle) begin
            $display("FAIL reset_outputs: got %h expected %h", obs, c_idle); n_err++;
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready: got %b expected 0", in_ready); n_err++;
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); n_err++;
        end
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        push(32'h002081B3, 8'h11);
        n_vec++;
        if (obs !== {1'b1, 4'b0010, 4'b0000, 8'h11}) begin
            $display("FAIL add_head: got %h expected %h", obs, {1'b1, 4'b0010, 4'b0000, 8'h11}); n_err++;
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL add_drained: got out_valid %b expected 0", out_valid); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        push(32'h402081B3, 8'h21);
        n_vec++;
        if (obs !== {1'b1, 4'b0110, 4'b0000, 8'h21} || in_ready !== 1'b1) begin
            $display("FAIL b2b_sub: got %h rdy %b expected %h rdy 1", obs, in_ready,
                     {1'b1, 4'b0110, 4'b0000, 8'h21}); n_err++;
        end
        push(32'h4030D093, 8'h22);
        n_vec++;
        if (obs !== {1'b1, 4'b1001, 4'b1000, 8'h22} || in_ready !== 1'b1) begin
            $display("FAIL b2b_srai: got %h rdy %b expected %h rdy 1", obs, in_ready,
                     {1'b1, 4'b1001, 4'b1000, 8'h22}); n_err++;
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_drained: got out_valid %b expected 0", out_valid); n_err++;
        end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        push(32'h00209063, 8'h31);
        n_vec++;
        if (obs !== {1'b1, 4'b0110, 4'b0100, 8'h31}) begin
            $display("FAIL bne: got %h expected %h", obs, {1'b1, 4'b0110, 4'b0100, 8'h31}); n_err++;
        end
        push(32'h0020D063, 8'h32);
        n_vec++;
        if (obs !== {1'b1, 4'b0111, 4'b0110, 8'h32}) begin
            $display("FAIL bge: got %h expected %h", obs, {1'b1, 4'b0111, 4'b0110, 8'h32}); n_err++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        push(32'h00000013, 8'h01);
        n_vec++;
        if (obs !== {1'b1, 4'b0010, 4'b1000, 8'h01} || in_ready !== 1'b1) begin
            $display("FAIL stall_first: got %h rdy %b expected %h rdy 1", obs, in_ready,
                     {1'b1, 4'b0010, 4'b1000, 8'h01}); n_err++;
        end
        push(32'h00000033, 8'h02);
        n_vec++;
        if (in_ready !== 1'b0) begin
            $display("FAIL stall_full_ready: got %b expected 0", in_ready); n_err++;
        end
        in_instr = 32'h00007033; in_tag = 8'h03;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (obs !== {1'b1, 4'b0010, 4'b1000, 8'h01} || in_ready !== 1'b0) begin
                $display("FAIL stall_hold%0d: got %h rdy %b expected %h rdy 0", i, obs, in_ready,
                         {1'b1, 4'b0010, 4'b1000, 8'h01}); n_err++;
            end
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (obs !== {1'b1, 4'b0010, 4'b0000, 8'h02} || in_ready !== 1'b1) begin
            $display("FAIL stall_second: got %h rdy %b expected %h rdy 1", obs, in_ready,
                     {1'b1, 4'b0010, 4'b0000, 8'h02}); n_err++;
        end
        tick();
        n_vec++;
        if (obs !== {1'b1, 4'b0000, 4'b0000, 8'h03}) begin
            $display("FAIL stall_third: got %h expected %h", obs, {1'b1, 4'b0000, 4'b0000, 8'h03}); n_err++;
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_drained: got out_valid %b expected 0", out_valid); n_err++;
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        push(32'hFFFFFFFF, 8'h41);
        push(32'h022081B3, 8'h42);
        in_valid = 1'b0;
        n_vec++;
        if (obs !== {1'b1, 4'b1111, 4'b0001, 8'h41}) begin
            $display("FAIL illegal_ones: got %h expected %h", obs, {1'b1, 4'b1111, 4'b0001, 8'h41}); n_err++;
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (obs !== {1'b1, 4'b1111, 4'b0001, 8'h42}) begin
            $display("FAIL illegal_mul: got %h expected %h", obs, {1'b1, 4'b1111, 4'b0001, 8'h42}); n_err++;
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL illegal_drained: got out_valid %b expected 0", out_valid); n_err++;
        end
    endtask

    task automatic test_decode_table();
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            push(tbl_instr[i], 8'(i));
            n_vec++;
            if (obs !== {1'b1, tbl_exp[i], 8'(i)}) begin
                $display("FAIL decode[%0d] instr %h: got %h expected %h", i, tbl_instr[i], obs,
                         {1'b1, tbl_exp[i], 8'(i)}); n_err++;
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(32'h002081B3, 8'h51);
        push(32'h002081B3, 8'h52);
        flush = 1'b1;
        in_instr = 32'h402081B3; in_tag = 8'h53;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (obs !== c_idle || in_ready !== 1'b1) begin
            $display("FAIL flush_full: got %h rdy %b expected %h rdy 1", obs, in_ready, c_idle); n_err++;
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_full_empty: got out_valid %b expected 0", out_valid); n_err++;
        end
        out_ready = 1'b0;
        push(32'h002081B3, 8'h54);
        flush = 1'b1;
        in_instr = 32'h402081B3; in_tag = 8'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (obs !== c_idle || in_ready !== 1'b1) begin
            $display("FAIL flush_push_drop: got %h rdy %b expected %h rdy 1", obs, in_ready, c_idle); n_err++;
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_push_empty: got out_valid %b expected 0", out_valid); n_err++;
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        push(32'h0020D063, 8'h61);
        push(32'hFFFFFFFF, 8'h62);
        reset = 1'b1;
        in_instr = 32'h002081B3; in_tag = 8'h63;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            $display("FAIL midreset_ready: got %b expected 0", in_ready); n_err++;
        end
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++;
        if (obs !== c_idle || in_ready !== 1'b1) begin
            $display("FAIL midreset_outputs: got %h rdy %b expected %h rdy 1", obs, in_ready, c_idle); n_err++;
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            $display("FAIL midreset_empty: got out_valid %b expected 0", out_valid); n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_branch();
        test_stall();
        test_illegal();
        test_decode_table();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Front end of the execute-stage integer ALU: decodes RV64I instruction words into the 4-bit ALU operation code and side-band controls the ALU consumes.
- Buffers decoded ops in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Sits between the ID stage and the EX-stage ALU; supplies ALU opcode, operand-B select and branch-resolve polarity.

Parameters:
- TAG_W, 8: width of the opaque tag (ROB/PC index) carried alongside each op.
- DEPTH, 2: buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered ops (pipeline redirect).
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  block can accept; high when fewer than 2 entries held.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  tag passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ALU stage consumes the head.
- out_aluop  out  4  ALU operation code.
- out_b_imm  out  1  1 selects the immediate as ALU operand B, 0 selects rs2.
- out_branch  out  1  op is a conditional branch compare.
- out_br_on_zero  out  1  branch taken when the ALU zero flag is 1.
- out_illegal  out  1  unsupported encoding; out_aluop is 4'b1111.
- out_tag  out  TAG_W  tag of the head entry.

Behaviour:
- ALU op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1001, NOR 1100, NOP/invalid 1111. NOR is never emitted.
- OP 0110011 (b_imm=0), by funct3:
  - 000: ADD if funct7=0000000, SUB if 0100000.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND.
  - 101: SRL if funct7=0000000, SRA if 0100000.
  - funct7=0100000 with any other funct3, or any other funct7, is illegal.
- OP-IMM 0010011 (b_imm=1): same mapping; 000 is always ADD.
  - 001 legal only when instr[31:26]=000000.
  - 101: SRL when instr[31:26]=000000, SRA when 010000, otherwise illegal.
- LOAD 0000011, STORE 0100011, JALR 1100111, AUIPC 0010111, LUI 0110111: ADD, b_imm=1.
- BRANCH 1100011 (b_imm=0, branch=1), by funct3:
  - BEQ 000: SUB, br_on_zero=1.
  - BNE 001: SUB, br_on_zero=0.
  - BLT 100: SLT, br_on_zero=0.
  - BGE 101: SLT, br_on_zero=1.
  - BLTU 110: SLTU, br_on_zero=0.
  - BGEU 111: SLTU, br_on_zero=1.
  - 010/011: illegal.
- Any other opcode: illegal.
- Illegal entries carry aluop=1111, b_imm=0, branch=0, br_on_zero=0, illegal=1. They still occupy a slot and are delivered in order.
- Buffer: 2-entry FIFO of {aluop, b_imm, branch, br_on_zero, illegal, tag}. Decode is combinational on in_instr; the write occurs on the accept edge.
  - Push when in_valid & in_ready; pop when out_valid & out_ready.
  - Latency: an op accepted at edge N is presented with out_valid=1 after edge N. No combinational in→out path.
  - in_ready = (count<2) & ~reset, combinational from registered count only; no dependence on out_ready.
  - Simultaneous push and pop at count=1: count stays 1; the new op becomes head on the next cycle.
  - At count=2, in_ready=0 and push is blocked.
  - Pop at count=0 is impossible, since out_valid=0.
- Output fields must not change while out_valid=1 & out_ready=0.
- When empty: out_valid=0, out_aluop=1111, all other outputs 0.
- Flush: on the edge where flush=1, count←0 and any simultaneous push is dropped. out_valid=0 and in_ready=1 on the next cycle. Flush has priority over push and pop.
- Reset (also mid-stream): count←0, pointers←0. out_valid=0, out_aluop=1111, out_tag=0, all other outputs 0.

Test Plan:
- Reset, then 0x002081B3 (add), tag 0x11, out_ready=1 → next cycle out_valid=1, aluop=0010, b_imm=0, tag=0x11; out_valid=0 the cycle after.
- 0x402081B3 (sub) then 0x4030D093 (srai) back-to-back, out_ready=1 → aluop 0110 then 1001 (b_imm=1), one per cycle, in_ready held 1.
- 0x00209063 (bne), 0x0020D063 (bge) → both aluop/branch correct (0110/1, 0111/1), br_on_zero 0 and 1 respectively.
- out_ready=0, push 3 ops (tags 1,2,3) → in_ready=0 after the 2nd accept, third held upstream; raise out_ready → tags 1,2,3 emerge in order, outputs stable while stalled.
- 0xFFFFFFFF and 0x022081B3 (mul encoding) → illegal=1, aluop=1111, delivered in order.
- Buffer full with flush=1 and a simultaneous in_valid → next cycle out_valid=0, in_ready=1, flushed op never appears; repeat with reset mid-stream → all outputs at reset values.
